// File: rtl/psum_accum_bramctrl.sv
// psum_accum_bramctrl
// ---------------------------------------------------------------------------
// PL-side user controller for the psum BRAM. It takes partial sums from the
// PE array and updates single-port BRAM port A through the mem_* port of the
// psum bus multiplexer.
//   - first=1 : plain overwrite of the addressed word.
//   - first=0 : read-modify-write (word + psum).
// The controller yields the bus whenever the PS owns it (i_conf_ctrl[2]=1).
//
// Build option:
//   PSUM_ACCUM_SAT_EN  defined   -> the accumulate add is signed saturating.
//                      undefined -> the accumulate add wraps modulo
//                                   2^DATA_WIDTH.
//   The first-pass (overwrite) path is the same in both builds.
//
// Ports:
//   clk, rst            single clock; synchronous active-high reset
//   i_conf_ctrl         control register, bit2 = PS owns the psum BRAM
//   i_psum_dat/addr     partial sum and its target word address
//   i_psum_first        1 = overwrite, 0 = accumulate
//   i_psum_vld          request valid
//   o_psum_rdy          ready
//   i_cnt_clr           clears o_wr_cnt (wins over a same-cycle write)
//   o_busy              FSM not in IDLE
//   o_err               sticky: PS took ownership while busy
//   o_wr_cnt            number of BRAM writes completed (wraps)
//   mem_addr/idat/odat  BRAM word address, write data, read data
//   mem_wren/enb/rst    byte write enables, enable, output reset (held 0)
//
// Handshake: a transfer happens at a rising edge where i_psum_vld and
// o_psum_rdy are both 1. o_psum_rdy never depends on i_psum_vld. Inputs are
// ignored while o_psum_rdy is 0. Only one transaction is in flight at a time,
// so there is no read-after-write hazard.
// ---------------------------------------------------------------------------
module psum_accum_bramctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_BYTE       = 4,
  parameter int REG_WIDTH      = 32,
  parameter int MEM_RD_LATENCY = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic [DATA_WIDTH-1:0] i_psum_dat,
  input  logic [ADDR_WIDTH-1:0] i_psum_addr,
  input  logic                  i_psum_first,
  input  logic                  i_psum_vld,
  output logic                  o_psum_rdy,
  input  logic                  i_cnt_clr,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_wr_cnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [NUM_BYTE-1:0]   mem_wren,
  output logic                  mem_enb,
  output logic                  mem_rst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_t;

  // WAIT lasts MEM_RD_LATENCY cycles; the counter runs down to 0 and the
  // read data is consumed in the cycle where it reads 0.
  localparam logic [1:0] WAIT_INIT = 2'(MEM_RD_LATENCY - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_dat;
  logic [1:0]            wait_cnt;
  logic                  own_q;      // i_conf_ctrl[2] delayed, for edge detect
  logic [DATA_WIDTH-1:0] sum;
  logic                  accept;

  // Only bit2 of the control register matters to this block.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{i_conf_ctrl[REG_WIDTH-1:3], i_conf_ctrl[1:0]};

  // The mux registers bit2 one cycle late, so ready must drop in the very
  // cycle bit2 rises to keep a cycle of margin. Held low while in reset.
  assign o_psum_rdy = (state == S_IDLE) & ~i_conf_ctrl[2] & ~rst;
  assign accept     = o_psum_rdy & i_psum_vld;
  assign mem_rst    = 1'b0;

`ifdef PSUM_ACCUM_SAT_EN
  // Sign-extended add; the two top bits disagree exactly on overflow, and
  // the extra top bit then tells the overflow direction.
  logic [DATA_WIDTH:0] sum_ext;
  always_comb begin
    sum_ext = {mem_odat[DATA_WIDTH-1], mem_odat} + {cap_dat[DATA_WIDTH-1], cap_dat};
    sum     = sum_ext[DATA_WIDTH-1:0];
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
      sum = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum = mem_odat + cap_dat;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cap_addr <= '0;
      cap_dat  <= '0;
      wait_cnt <= '0;
      own_q    <= 1'b0;
      o_busy   <= 1'b0;
      o_err    <= 1'b0;
      o_wr_cnt <= '0;
      mem_addr <= '0;
      mem_idat <= '0;
      mem_wren <= '0;
      mem_enb  <= 1'b0;
    end else begin
      own_q <= i_conf_ctrl[2];
      if (o_busy && i_conf_ctrl[2] && !own_q) begin
        o_err <= 1'b1;
      end

      // Clear wins over a write completing in the same cycle.
      if (i_cnt_clr) begin
        o_wr_cnt <= '0;
      end else if (state == S_WR) begin
        o_wr_cnt <= o_wr_cnt + CNT_WIDTH'(1);
      end

      // Enables are single-cycle pulses; address and data hold.
      mem_enb  <= 1'b0;
      mem_wren <= '0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_addr <= i_psum_addr;
            cap_dat  <= i_psum_dat;
            mem_addr <= i_psum_addr;
            mem_enb  <= 1'b1;
            o_busy   <= 1'b1;
            if (i_psum_first) begin
              mem_idat <= i_psum_dat;
              mem_wren <= {NUM_BYTE{1'b1}};
              state    <= S_WR;
            end else begin
              state    <= S_RD;
            end
          end
        end
        S_RD: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            mem_idat <= sum;
            mem_addr <= cap_addr;
            mem_enb  <= 1'b1;
            mem_wren <= {NUM_BYTE{1'b1}};
            state    <= S_WR;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_WR: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_bramctrl.sv
// Testbench for psum_accum_bramctrl: directed scenarios plus a randomized
// run. A small BRAM model serves the mem_* port; a reference model of the
// psum memory predicts every write (address, data, cycle), and a monitor
// compares each observed write against the expected queue.
module tb_psum_accum_bramctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = 4;
  localparam int RW = 32;
  localparam int L  = 1;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] i_conf_ctrl;
  logic [DW-1:0] i_psum_dat;
  logic [AW-1:0] i_psum_addr;
  logic          i_psum_first;
  logic          i_psum_vld;
  logic          o_psum_rdy;
  logic          i_cnt_clr;
  logic          o_busy;
  logic          o_err;
  logic [CW-1:0] o_wr_cnt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_idat;
  logic [DW-1:0] mem_odat;
  logic [NB-1:0] mem_wren;
  logic          mem_enb;
  logic          mem_rst;

  psum_accum_bramctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTE(NB),
    .REG_WIDTH(RW), .MEM_RD_LATENCY(L), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_conf_ctrl(i_conf_ctrl),
    .i_psum_dat(i_psum_dat), .i_psum_addr(i_psum_addr),
    .i_psum_first(i_psum_first), .i_psum_vld(i_psum_vld),
    .o_psum_rdy(o_psum_rdy), .i_cnt_clr(i_cnt_clr), .o_busy(o_busy),
    .o_err(o_err), .o_wr_cnt(o_wr_cnt), .mem_addr(mem_addr),
    .mem_idat(mem_idat), .mem_odat(mem_odat), .mem_wren(mem_wren),
    .mem_enb(mem_enb), .mem_rst(mem_rst)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM model (environment) ----------------
  logic [DW-1:0] bram [16];
  logic [DW-1:0] rd0, rd1;
  always @(posedge clk) begin
    if (mem_enb && mem_wren == {NB{1'b1}}) bram[mem_addr[3:0]] <= mem_idat;
    if (mem_enb) rd0 <= bram[mem_addr[3:0]];
    rd1 <= rd0;
  end
  assign mem_odat = (L == 1) ? rd0 : rd1;

  // ---------------- scoreboard ----------------
  int nasrt = 0;
  int nfail = 0;
  logic [63:0] exp_q[$];      // {addr, data}
  int          exp_cyc_q[$];  // cycle in which the write must be seen
  bit          exp_dc_q[$];   // data is don't-care for this write
  logic [DW-1:0] ref_mem [16];
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nasrt++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: word after an update, from plain integer arithmetic.
  function automatic logic [DW-1:0] acc(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    logic [63:0] sv;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_ACCUM_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7fff_ffff;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    sv = s;
    return sv[31:0];
  endfunction

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [63:0] e;
    int          c;
    bit          dc;
    if (mem_wren != '0) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        c  = exp_cyc_q.pop_front();
        dc = exp_dc_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        if (!dc) chk("wr_data", mem_idat, e[31:0]);
        chk("wr_cycle", cyc, c);
        chk("wr_enb", mem_enb, 1);
        chk("wr_wren", mem_wren, {NB{1'b1}});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request and waits for acceptance. vld stays high afterwards;
  // callers drop it explicitly. keep=0 means the write is not expected.
  task automatic send(input logic [3:0] a, input logic [DW-1:0] d, input bit f,
                      input bit dc, input bit keep, output int t);
    int waited = 0;
    bit ok = 0;
    logic [DW-1:0] w;
    t = 0;
    while (!ok && waited < 100) begin
      @(negedge clk);
      i_psum_addr  = AW'(a);
      i_psum_dat   = d;
      i_psum_first = f;
      i_psum_vld   = 1'b1;
      #1;
      if (o_psum_rdy) ok = 1;
      else waited++;
    end
    if (!ok) begin
      chk("send_timeout", 64'd0, 64'd1);
      i_psum_vld = 1'b0;
      return;
    end
    t = cyc;
    if (keep) begin
      w = f ? d : acc(ref_mem[a], d);
      ref_mem[a] = w;
      exp_q.push_back({32'(a), w});
      exp_cyc_q.push_back(t + (f ? 1 : 2 + L));
      exp_dc_q.push_back(dc);
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    i_psum_vld = 1'b0;
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", o_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdy"}, o_psum_rdy, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_cnt"}, o_wr_cnt, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_idat"}, mem_idat, 0);
    chk({tag, "_wren"}, mem_wren, 0);
    chk({tag, "_enb"}, mem_enb, 0);
    chk({tag, "_mrst"}, mem_rst, 0);
  endtask

  // ---------------- stimulus ----------------
  int t1, t2, tp;
  int ts [4];
  logic [DW-1:0] edge_vals [4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end
    rd0 = '0; rd1 = '0;
    edge_vals[0] = 32'h7fff_ffff; edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'hffff_ffff; edge_vals[3] = 32'h0000_0001;
    rst = 1'b1; i_conf_ctrl = '0; i_psum_dat = '0; i_psum_addr = '0;
    i_psum_first = 1'b0; i_psum_vld = 1'b0; i_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: overwrite then accumulate on the same word
    send(4'd5, 32'd10, 1'b1, 1'b0, 1'b1, t1);
    send(4'd5, 32'd7, 1'b0, 1'b0, 1'b1, t2);
    wait_idle();
    chk("t1_cnt", o_wr_cnt, 64'd2);
    chk("t1_word", bram[5], 64'd17);

    // 2: back-to-back accumulates, vld held high
    for (int i = 0; i < 4; i++) send(4'd3, 32'd1, 1'b0, 1'b0, 1'b1, ts[i]);
    for (int i = 1; i < 4; i++) chk("t2_spacing", ts[i] - ts[i-1], 3 + L);
    wait_idle();
    chk("t2_word", bram[3], 64'd4);
    chk("t2_cnt", o_wr_cnt, exp_cnt);

    // 3: overflow at the positive limit
    send(4'd12, 32'h7fff_ffff, 1'b1, 1'b0, 1'b1, tp);
    send(4'd12, 32'd1, 1'b0, 1'b0, 1'b1, tp);
    wait_idle();
`ifdef PSUM_ACCUM_SAT_EN
    chk("t3_sat", bram[12], 64'h7fff_ffff);
`else
    chk("t3_wrap", bram[12], 64'h8000_0000);
`endif

    // 4: PS owns the bus while idle -> request held off
    @(negedge clk);
    i_conf_ctrl[2] = 1'b1;
    i_psum_vld = 1'b1; i_psum_addr = 32'd6; i_psum_dat = 32'd55; i_psum_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_rdy", o_psum_rdy, 0);
      chk("t4_enb", mem_enb, 0);
      chk("t4_err", o_err, 0);
    end
    i_conf_ctrl[2] = 1'b0;
    i_psum_vld = 1'b0;
    send(4'd6, 32'd55, 1'b1, 1'b0, 1'b1, tp);
    wait_idle();
    chk("t4_word", bram[6], 64'd55);

    // 5: PS takes the bus during WAIT -> write still issued, sticky error
    send(4'd9, $urandom, 1'b0, 1'b1, 1'b1, tp);
    @(posedge clk);
    @(negedge clk);
    i_conf_ctrl[2] = 1'b1;
    wait_idle();
    chk("t5_err", o_err, 1);
    @(negedge clk);
    i_conf_ctrl[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", o_err, 1);

    // 6a: reset during WAIT abandons the transaction
    send(4'd4, 32'd3, 1'b0, 1'b0, 1'b0, tp);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    i_psum_vld = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (4) @(negedge clk);
    chk("t6_no_wr", bram[4], 64'd0);
    chk("t6_pending", exp_q.size(), 0);

    // 6b: clear coincident with WR
    send(4'd2, 32'd77, 1'b1, 1'b0, 1'b1, tp);
    @(negedge clk);
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
    exp_cnt = 0;
    wait_idle();
    chk("t6_clr", o_wr_cnt, 64'd0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      send(4'($urandom_range(0, 7)), d, ($urandom_range(0, 3) == 0), 1'b0, 1'b1, tp);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        i_psum_vld = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_idle();
    chk("rand_cnt", o_wr_cnt, exp_cnt);
    repeat (3) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
